// File: rtl/riscv_hwloop_ctrl_regs.sv
// Hardware-loop register file and loop-back unit for the fetch path.
// Holds N_REGS loop sets (start, end, counter), picks the innermost loop whose
// end address matches the fetch PC, issues the jump back to its start and
// decrements its counter.
// Optional macro HWLP_STATS_EN adds per-set taken-jump statistics counters.
module riscv_hwloop_ctrl_regs #(
    parameter int unsigned N_REGS     = 2,
    parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_WIDTH-1:0]                hwlp_start_data_i,
    input  logic [ADDR_WIDTH-1:0]                hwlp_end_data_i,
    input  logic [CNT_WIDTH-1:0]                 hwlp_cnt_data_i,
    input  logic [2:0]                           hwlp_we_i,
    input  logic [N_REG_BITS-1:0]                hwlp_regid_i,
    input  logic [ADDR_WIDTH-1:0]                fetch_pc_i,
    input  logic                                 fetch_valid_i,
    output logic                                 hwlp_jump_o,
    output logic [ADDR_WIDTH-1:0]                hwlp_target_o,
    output logic [N_REGS-1:0]                    hwlp_sel_o,
    output logic [N_REGS-1:0]                    hwlp_active_o,
    output logic [N_REGS-1:0][ADDR_WIDTH-1:0]    hwlp_start_addr_o,
    output logic [N_REGS-1:0][ADDR_WIDTH-1:0]    hwlp_end_addr_o,
    output logic [N_REGS-1:0][CNT_WIDTH-1:0]     hwlp_counter_o,
    output logic [N_REGS-1:0][31:0]              hwlp_iter_count_o
);

    localparam int unsigned STAT_WIDTH = 32;

    logic [N_REGS-1:0][ADDR_WIDTH-1:0] start_q;
    logic [N_REGS-1:0][ADDR_WIDTH-1:0] end_q;
    logic [N_REGS-1:0][CNT_WIDTH-1:0]  cnt_q;

    logic [N_REGS-1:0]                 match;
    logic [N_REGS-1:0][2:0]            we_set;
    logic [N_REGS-1:0]                 dec;
    logic [N_REG_BITS-1:0]             sel_idx;
    logic                              any_match;

    assign hwlp_start_addr_o = start_q;
    assign hwlp_end_addr_o   = end_q;
    assign hwlp_counter_o    = cnt_q;

    // Per-set activity, end-address match and write/decrement strobes
    always_comb begin
        for (int k = 0; k < int'(N_REGS); k++) begin
            hwlp_active_o[k] = (cnt_q[k] != '0);
            match[k]         = hwlp_active_o[k] && (fetch_pc_i == end_q[k]);
            // full-width compare so out-of-range ids hit no set
            we_set[k]        = (32'(hwlp_regid_i) == 32'(k)) ? hwlp_we_i : 3'b000;
        end
    end

    // Innermost (lowest index) match selection, jump and target
    always_comb begin
        sel_idx       = '0;
        any_match     = 1'b0;
        hwlp_sel_o    = '0;
        hwlp_target_o = '0;
        hwlp_jump_o   = 1'b0;
        for (int k = int'(N_REGS) - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel_idx   = N_REG_BITS'(k);
                any_match = 1'b1;
            end
        end
        if (any_match) begin
            hwlp_sel_o[sel_idx] = 1'b1;
            hwlp_target_o       = start_q[sel_idx];
            hwlp_jump_o         = fetch_valid_i && (cnt_q[sel_idx] >= CNT_WIDTH'(2));
        end
    end

    // Only the selected set decrements, and never below zero
    always_comb begin
        for (int k = 0; k < int'(N_REGS); k++) begin
            dec[k] = fetch_valid_i && hwlp_sel_o[k] && (cnt_q[k] != '0);
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_set
        // Loop-set registers; a counter write overrides a same-cycle decrement
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                start_q[g] <= '0;
                end_q[g]   <= '0;
                cnt_q[g]   <= '0;
            end else begin
                if (we_set[g][0]) begin
                    start_q[g] <= {hwlp_start_data_i[ADDR_WIDTH-1:1], 1'b0};
                end
                if (we_set[g][1]) begin
                    end_q[g] <= {hwlp_end_data_i[ADDR_WIDTH-1:1], 1'b0};
                end
                if (we_set[g][2]) begin
                    cnt_q[g] <= hwlp_cnt_data_i;
                end else if (dec[g]) begin
                    cnt_q[g] <= cnt_q[g] - CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef HWLP_STATS_EN
    logic [N_REGS-1:0][STAT_WIDTH-1:0] stats_q;

    for (genvar g = 0; g < N_REGS; g++) begin : g_stats
        // Taken-jump count per set; cleared when its counter is rewritten
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stats_q[g] <= '0;
            end else if (we_set[g][2]) begin
                stats_q[g] <= '0;
            end else if (hwlp_sel_o[g] && hwlp_jump_o) begin
                stats_q[g] <= stats_q[g] + STAT_WIDTH'(1);
            end
        end
    end

    assign hwlp_iter_count_o = stats_q;
`else
    assign hwlp_iter_count_o = '0;
`endif

endmodule

// File: tb/tb_riscv_hwloop_ctrl_regs.sv
// Directed bench for riscv_hwloop_ctrl_regs: stimulus pushes expected values
// into a queue and a monitor compares them a moment after inputs settle.
module tb_riscv_hwloop_ctrl_regs;

    localparam int unsigned N_REGS     = 2;
    localparam int unsigned N_REG_BITS = 1;
    localparam int unsigned AW         = 32;
    localparam int unsigned CW         = 32;

    localparam int S_JUMP   = 0;
    localparam int S_TARGET = 1;
    localparam int S_SEL    = 2;
    localparam int S_ACTIVE = 3;
    localparam int S_START0 = 4;
    localparam int S_END0   = 5;
    localparam int S_CNT0   = 6;
    localparam int S_CNT1   = 7;
    localparam int S_START1 = 8;
    localparam int S_ITER0  = 9;
    localparam int S_ITER1  = 10;

`ifdef HWLP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic [AW-1:0]                   start_d = '0;
    logic [AW-1:0]                   end_d = '0;
    logic [CW-1:0]                   cnt_d = '0;
    logic [2:0]                      we = '0;
    logic [N_REG_BITS-1:0]           regid = '0;
    logic [AW-1:0]                   pc = '0;
    logic                            valid = 1'b0;
    logic                            jump;
    logic [AW-1:0]                   target;
    logic [N_REGS-1:0]               sel;
    logic [N_REGS-1:0]               active;
    logic [N_REGS-1:0][AW-1:0]       start_a;
    logic [N_REGS-1:0][AW-1:0]       end_a;
    logic [N_REGS-1:0][CW-1:0]       cnt_a;
    logic [N_REGS-1:0][31:0]         iter_a;

    riscv_hwloop_ctrl_regs #(
        .N_REGS(N_REGS), .N_REG_BITS(N_REG_BITS), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hwlp_start_data_i(start_d),
        .hwlp_end_data_i  (end_d),
        .hwlp_cnt_data_i  (cnt_d),
        .hwlp_we_i        (we),
        .hwlp_regid_i     (regid),
        .fetch_pc_i       (pc),
        .fetch_valid_i    (valid),
        .hwlp_jump_o      (jump),
        .hwlp_target_o    (target),
        .hwlp_sel_o       (sel),
        .hwlp_active_o    (active),
        .hwlp_start_addr_o(start_a),
        .hwlp_end_addr_o  (end_a),
        .hwlp_counter_o   (cnt_a),
        .hwlp_iter_count_o(iter_a)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] mon_act;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] get_sig(input int s);
        case (s)
            S_JUMP:   return 32'(jump);
            S_TARGET: return target;
            S_SEL:    return 32'(sel);
            S_ACTIVE: return 32'(active);
            S_START0: return start_a[0];
            S_END0:   return end_a[0];
            S_CNT0:   return cnt_a[0];
            S_CNT1:   return cnt_a[1];
            S_START1: return start_a[1];
            S_ITER0:  return iter_a[0];
            S_ITER1:  return iter_a[1];
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp_push(input int s, input logic [31:0] v, input string nm);
        exp_t e;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after the falling edge
    task automatic drive(input logic [31:0] p, input logic v, input logic [2:0] w,
                         input logic rid, input logic [31:0] s, input logic [31:0] e,
                         input logic [31:0] c);
        @(negedge clk);
        #1;
        pc      = p;
        valid   = v;
        we      = w;
        regid   = rid;
        start_d = s;
        end_d   = e;
        cnt_d   = c;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: outputs are stable 2 units after the falling edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                mon_e   = exp_q.pop_front();
                mon_act = get_sig(mon_e.sig);
                checks++;
                if (mon_act !== mon_e.val) begin
                    errors++;
                    $display("FAIL %s actual %h required %h", mon_e.name, mon_act, mon_e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual running required finished");
        $fatal(1);
    end

    initial begin
        // reset held: everything zero, even with a valid PC at address 0
        drive(32'h0, 1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0);
        exp_push(S_CNT0, 32'h0, "rst_cnt0");
        exp_push(S_START0, 32'h0, "rst_start0");
        exp_push(S_ACTIVE, 32'h0, "rst_active");
        exp_push(S_JUMP, 32'h0, "rst_jump");
        exp_push(S_SEL, 32'h0, "rst_sel");
        exp_push(S_ITER0, 32'h0, "rst_iter0");
        idle();
        rst_n = 1'b1;

        // test 1: write set 0, visible only after the edge
        drive(32'h0, 1'b0, 3'b111, 1'b0, 32'h100, 32'h121, 32'd3);
        exp_push(S_ACTIVE, 32'h0, "wr_not_yet_visible");
        idle();
        exp_push(S_START0, 32'h100, "wr_start0");
        exp_push(S_END0, 32'h120, "wr_end0_aligned");
        exp_push(S_CNT0, 32'd3, "wr_cnt0");
        exp_push(S_ACTIVE, 32'h1, "wr_active0");

        // test 2: basic loop, three passes
        drive(32'h120, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_JUMP, 32'h1, "loop1_jump");
        exp_push(S_TARGET, 32'h100, "loop1_target");
        exp_push(S_SEL, 32'h1, "loop1_sel");
        drive(32'h120, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_CNT0, 32'd2, "loop2_cnt");
        exp_push(S_JUMP, 32'h1, "loop2_jump");
        drive(32'h120, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_CNT0, 32'd1, "loop3_cnt");
        exp_push(S_JUMP, 32'h0, "loop3_fallthrough");
        exp_push(S_SEL, 32'h1, "loop3_sel");
        exp_push(S_TARGET, 32'h100, "loop3_target");
        drive(32'h120, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_CNT0, 32'd0, "loop_done_cnt");
        exp_push(S_ACTIVE, 32'h0, "loop_done_active");
        exp_push(S_SEL, 32'h0, "loop_done_sel");
        exp_push(S_JUMP, 32'h0, "loop_done_jump");
        exp_push(S_TARGET, 32'h0, "loop_done_target");
        exp_push(S_ITER0, STATS ? 32'd2 : 32'd0, "stats_iter0_after_loop");

        // test 6: counter rewrite clears statistics
        drive(32'h0, 1'b0, 3'b100, 1'b0, 0, 0, 32'd3);
        idle();
        exp_push(S_ITER0, 32'd0, "stats_iter0_cleared");
        exp_push(S_CNT0, 32'd3, "rewrite_cnt0");

        // test 3: nesting with shared end address
        drive(32'h0, 1'b0, 3'b111, 1'b0, 32'h200, 32'h220, 32'd2);
        drive(32'h0, 1'b0, 3'b111, 1'b1, 32'h1F0, 32'h220, 32'd2);
        drive(32'h220, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_SEL, 32'h1, "nest_sel_inner");
        exp_push(S_JUMP, 32'h1, "nest_jump_inner");
        exp_push(S_TARGET, 32'h200, "nest_target_inner");
        exp_push(S_START1, 32'h1F0, "nest_start1");
        drive(32'h220, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_CNT0, 32'd1, "nest_cnt0_dec");
        exp_push(S_CNT1, 32'd2, "nest_cnt1_untouched");
        exp_push(S_JUMP, 32'h0, "nest_inner_exit");
        drive(32'h220, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_CNT0, 32'd0, "nest_cnt0_zero");
        exp_push(S_CNT1, 32'd2, "nest_cnt1_still");
        exp_push(S_SEL, 32'h2, "nest_sel_outer");
        exp_push(S_JUMP, 32'h1, "nest_jump_outer");
        exp_push(S_TARGET, 32'h1F0, "nest_target_outer");
        idle();
        exp_push(S_CNT1, 32'd1, "nest_cnt1_dec");
        exp_push(S_ITER1, STATS ? 32'd1 : 32'd0, "stats_iter1");

        // test 4: write vs decrement on the same set
        drive(32'h0, 1'b0, 3'b100, 1'b0, 0, 0, 32'd5);
        drive(32'h220, 1'b1, 3'b100, 1'b0, 0, 0, 32'd9);
        exp_push(S_JUMP, 32'h1, "coll_same_jump");
        idle();
        exp_push(S_CNT0, 32'd9, "coll_same_write_wins");
        // write vs decrement on different sets
        drive(32'h0, 1'b0, 3'b100, 1'b0, 0, 0, 32'd5);
        drive(32'h220, 1'b1, 3'b100, 1'b1, 0, 0, 32'd9);
        exp_push(S_SEL, 32'h1, "coll_diff_sel");
        idle();
        exp_push(S_CNT0, 32'd4, "coll_diff_cnt0");
        exp_push(S_CNT1, 32'd9, "coll_diff_cnt1");

        // test 5: zero counts never match
        drive(32'h0, 1'b0, 3'b100, 1'b0, 0, 0, 32'd0);
        drive(32'h0, 1'b0, 3'b100, 1'b1, 0, 0, 32'd0);
        drive(32'h220, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_SEL, 32'h0, "zero_cnt_sel");
        exp_push(S_JUMP, 32'h0, "zero_cnt_jump");
        exp_push(S_TARGET, 32'h0, "zero_cnt_target");
        exp_push(S_ACTIVE, 32'h0, "zero_cnt_active");
        // fetch not valid: match shown, no jump, no decrement
        drive(32'h0, 1'b0, 3'b100, 1'b0, 0, 0, 32'd4);
        drive(32'h220, 1'b0, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_SEL, 32'h1, "novalid_sel");
        exp_push(S_JUMP, 32'h0, "novalid_jump");
        exp_push(S_TARGET, 32'h200, "novalid_target");
        drive(32'h220, 1'b0, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_CNT0, 32'd4, "novalid_cnt_hold");
        // PC one halfword off the end address
        drive(32'h222, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        exp_push(S_SEL, 32'h0, "pc_miss_sel");
        exp_push(S_JUMP, 32'h0, "pc_miss_jump");
        // asynchronous reset mid-loop
        drive(32'h220, 1'b1, 3'b000, 1'b0, 0, 0, 0);
        rst_n = 1'b0;
        exp_push(S_CNT0, 32'h0, "arst_cnt0");
        exp_push(S_START0, 32'h0, "arst_start0");
        exp_push(S_END0, 32'h0, "arst_end0");
        exp_push(S_JUMP, 32'h0, "arst_jump");
        exp_push(S_SEL, 32'h0, "arst_sel");
        exp_push(S_ACTIVE, 32'h0, "arst_active");
        idle();
        rst_n = 1'b1;
        idle();
        exp_push(S_CNT0, 32'h0, "post_rst_cnt0");

        @(negedge clk);
        #3;
        checks++;
        if (cnt_a[0] !== 32'h0) begin
            errors++;
            $display("FAIL final_cnt0 actual %h required %h", cnt_a[0], 32'h0);
        end
        checks++;
        if (end_a[0] !== 32'h0) begin
            errors++;
            $display("FAIL final_end0 actual %h required %h", end_a[0], 32'h0);
        end
        checks++;
        if (active !== 2'b00) begin
            errors++;
            $display("FAIL final_active actual %h required %h", active, 2'b00);
        end
        checks++;
        if (sel !== 2'b00) begin
            errors++;
            $display("FAIL final_sel actual %h required %h", sel, 2'b00);
        end
        checks++;
        if (jump !== 1'b0) begin
            errors++;
            $display("FAIL final_jump actual %h required %h", jump, 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_hwloop_ctrl_regs.md
Name: riscv_hwloop_ctrl_regs

Overview:
Next-generation hardware-loop register file and loop-back unit for the RI5CY fetch path. It holds N_REGS loop sets, each with a start address, an end address and an iteration counter. It compares the fetch PC against every end address and selects the innermost matching loop. When that loop still has iterations left, it issues a jump to the loop's start address. It also decrements the selected counter itself, so no separate decrement request is needed.

Parameters:
N_REGS, 2, number of hardware-loop sets; index 0 is the innermost loop and has the highest priority.
N_REG_BITS, $clog2(N_REGS) (minimum 1), width of the register-set index.
ADDR_WIDTH, 32, width of the start/end addresses and of the PC.
CNT_WIDTH, 32, width of the iteration counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
hwlp_start_data_i  in  ADDR_WIDTH  start address write data
hwlp_end_data_i  in  ADDR_WIDTH  end address write data
hwlp_cnt_data_i  in  CNT_WIDTH  counter write data
hwlp_we_i  in  3  write enables: bit 0 = start, bit 1 = end, bit 2 = counter
hwlp_regid_i  in  N_REG_BITS  target set for the writes
fetch_pc_i  in  ADDR_WIDTH  PC of the instruction being fetched
fetch_valid_i  in  1  fetch_pc_i is valid and the fetch advances this cycle
hwlp_jump_o  out  1  redirect fetch to hwlp_target_o
hwlp_target_o  out  ADDR_WIDTH  start address of the selected loop
hwlp_sel_o  out  N_REGS  one-hot selected loop; all zero when no match
hwlp_active_o  out  N_REGS  per-set flag, high when the counter is non-zero
hwlp_start_addr_o  out  N_REGS x ADDR_WIDTH  stored start addresses
hwlp_end_addr_o  out  N_REGS x ADDR_WIDTH  stored end addresses
hwlp_counter_o  out  N_REGS x CNT_WIDTH  stored counters
hwlp_iter_count_o  out  N_REGS x 32  taken-jump statistics (see Optional Feature)

Behaviour:
- Reset: all start, end and counter registers are 0. All outputs are 0 while rst_n is low. Asserting rst_n mid-loop aborts every loop immediately.
- Writes:
  - A write lands on the next clk edge.
  - Bit 0 of each written start and end address is forced to 0 (halfword alignment).
  - A write with hwlp_regid_i >= N_REGS is ignored.
  - Any mix of the three enables may be asserted in the same cycle.
- Match detection (combinational):
  - match[k] = hwlp_active_o[k] AND (fetch_pc_i == end_q[k]).
  - sel is the lowest-index match; hwlp_sel_o is one-hot or all zero.
  - A set with counter 0 never matches.
- Jump:
  - hwlp_jump_o = fetch_valid_i AND (a match exists) AND (selected counter >= 2).
  - hwlp_target_o = start_q[sel]; it is 0 when there is no match.
  - Both outputs are zero-latency, in the same cycle as the PC.
- Decrement:
  - When fetch_valid_i is high and a match exists, counter[sel] decrements by 1 on the next edge.
  - With counter == 1 there is no jump, fetch falls through, the counter goes to 0 and the loop becomes inactive.
  - Only the selected set decrements; an outer set sharing the same end address is untouched in that cycle.
  - The counter never wraps below 0.
- Simultaneous write and decrement:
  - On the same set, the write wins and the decrement is lost.
  - On different sets, both take effect.
- Visibility: a newly written value takes part in match detection from the cycle after the write edge. There is no bypass.
- When fetch_valid_i is low, the outputs still reflect the match, but hwlp_jump_o is low and no state changes.

Optional Feature:
- Macro: HWLP_STATS_EN.
- Defined:
  - Each set has a 32-bit counter that increments on every cycle in which that set is selected and hwlp_jump_o is high.
  - The statistics counter wraps from 0xFFFFFFFF to 0.
  - It clears to 0 on a counter write (hwlp_we_i[2]) to that set, and on reset.
  - Its value drives hwlp_iter_count_o.
- Not defined: hwlp_iter_count_o is tied to 0 and no statistics flops exist.

Test Plan:
1. Reset and write: after reset, write set 0 with start=0x100, end=0x121 and count=3 → registers read back 0x100, 0x120 and 3; active[0]=1 on the next cycle.
2. Basic loop: set 0 as in test 1; present pc=0x120 valid for three passes → jump=1 with target=0x100 twice; the third pass gives jump=0; counter goes 3→2→1→0 and active[0]=0.
3. Nesting: set 0 = (0x200, 0x220, 2) and set 1 = (0x1F0, 0x220, 2); pc=0x220 → sel=01 and only counter 0 decrements; once counter 0 is 0, pc=0x220 → sel=10 and set 1 jumps to 0x1F0.
4. Collision: set 0 count=5 at pc=end with a counter write of 9 to set 0 in the same cycle → counter=9, not 4. The same stimulus with regid=1 → set 0 counter=4 and set 1 counter=9.
5. Edge cases: count=0 at pc=end → no match and no jump. fetch_valid_i=0 at pc=end → counter unchanged. rst_n pulsed low mid-loop → all registers 0 asynchronously.
6. HWLP_STATS_EN: run test 2 → iter_count[0]=2; rewriting the counter of set 0 → iter_count[0]=0. With the macro off, the output stays 0 throughout.
